banked_mem_responder: RTL and testbench

Four-bank, word-interleaved main-memory responder that services the cache controller's block fill and writeback traffic. Accepts one read or write request per cycle, returns read data a fixed two cycles after acceptance, and holds each bank busy for four cycles. It raises `stall` when a request targets a busy bank and `err` on illegal requests.

---
 rtl/banked_mem_responder_if.sv | 24 ++
 rtl/banked_mem_responder.sv | 75 +++++++
 tb/tb_banked_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller and the banked memory responder.
// A request is rd|wr in a cycle; it is taken only if err=0 and stall=0 in that same cycle,
// otherwise it is dropped and the master must re-present it. No ready/valid back-pressure exists.
interface banked_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder: one request per cycle, fixed two-cycle
// read latency, each bank occupied BANK_CYC cycles per access.
module banked_mem_responder #(
    parameter int IDX_W    = 13,
    parameter int BANK_CYC = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    banked_mem_responder_if.slave bus
);
    localparam int CNT_W = $clog2(BANK_CYC + 1);
    localparam int DEPTH = 1 << IDX_W;

    logic             present;
    logic             err;
    logic             stall;
    logic             accept;
    logic [1:0]       bank;
    logic [IDX_W-1:0] idx;
    logic [3:0]       busy;
    logic [CNT_W-1:0] cnt [4];

    logic [15:0] mem [4][DEPTH];
    logic        s1_valid, s2_valid;
    logic [15:0] s1_data, s2_data;

    assign bank    = bus.addr[2:1];
    assign idx     = bus.addr[3 +: IDX_W];
    assign present = bus.rd | bus.wr;
    assign err     = (bus.rd & bus.wr) | (present & bus.addr[0]);
    assign stall   = present & ~err & busy[bank];
    assign accept  = present & ~err & ~stall;

    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++) busy[i] = (cnt[i] != '0);
    end

    // Counter is loaded on accept and counts down, so busy covers accept+1 .. accept+BANK_CYC-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && bank == 2'(i))
                    cnt[i] <= CNT_W'(BANK_CYC - 1);
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept & bus.rd;
            s2_valid <= s1_valid;
        end
    end

    // Storage and read data are deliberately outside reset: memory survives a reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) mem[bank][idx] <= bus.data_in;
        s1_data <= mem[bank][idx];
        s2_data <= s1_data;
    end

    assign bus.data_out   = s2_valid ? s2_data : 16'h0000;
    assign bus.data_valid = s2_valid;
    assign bus.stall      = stall;
    assign bus.busy       = busy;
    assign bus.err        = err;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: a per-cycle vector table plus a hand-written
// reset-during-read sequence.
module tb_banked_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_mem_responder_if bif ();
  banked_mem_responder #(.IDX_W(13), .BANK_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic        ee;
    logic [3:0]  eb;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t v(logic rd, logic wr, logic [15:0] addr, logic [15:0] din,
                             logic ev, logic [15:0] ed, logic es, logic ee, logic [3:0] eb);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.din = din;
    r.ev = ev; r.ed = ed; r.es = es; r.ee = ee; r.eb = eb;
    return r;
  endfunction

  function automatic vec_t idle(logic ev, logic [15:0] ed, logic [3:0] eb);
    return v(1'b0, 1'b0, 16'h0, 16'h0, ev, ed, 1'b0, 1'b0, eb);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic rd, logic wr, logic [15:0] addr, logic [15:0] din);
    bif.rd = rd; bif.wr = wr; bif.addr = addr; bif.data_in = din;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 16'h0, 16'h0);

    // Reset state
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    // Write/read basic: BEEF @0x0006 (bank 3), read back at +4
    tbl.push_back(v(0, 1, 16'h0006, 16'hBEEF, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(v(1, 0, 16'h0006, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(1, 16'hBEEF, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    // Preload block 0x1230..0x1236 with A0..A3 (banks 0..3)
    tbl.push_back(v(0, 1, 16'h1230, 16'h00A0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(v(0, 1, 16'h1232, 16'h00A1, 0, 16'h0, 0, 0, 4'b0001));
    tbl.push_back(v(0, 1, 16'h1234, 16'h00A2, 0, 16'h0, 0, 0, 4'b0011));
    tbl.push_back(v(0, 1, 16'h1236, 16'h00A3, 0, 16'h0, 0, 0, 4'b0111));
    tbl.push_back(idle(0, 16'h0, 4'b1110));
    tbl.push_back(idle(0, 16'h0, 4'b1100));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    // Interleaved block read, back to back, data at +2
    tbl.push_back(v(1, 0, 16'h1230, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(v(1, 0, 16'h1232, 16'h0, 0, 16'h0, 0, 0, 4'b0001));
    tbl.push_back(v(1, 0, 16'h1234, 16'h0, 1, 16'h00A0, 0, 0, 4'b0011));
    tbl.push_back(v(1, 0, 16'h1236, 16'h0, 1, 16'h00A1, 0, 0, 4'b0111));
    tbl.push_back(idle(1, 16'h00A2, 4'b1110));
    tbl.push_back(idle(1, 16'h00A3, 4'b1100));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    // Bank conflict: second bank-0 write stalls three cycles (incl. counter 1->0 cycle)
    tbl.push_back(v(0, 1, 16'h0000, 16'h1111, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(v(0, 1, 16'h0008, 16'h2222, 0, 16'h0, 1, 0, 4'b0001));
    tbl.push_back(v(0, 1, 16'h0008, 16'h2222, 0, 16'h0, 1, 0, 4'b0001));
    tbl.push_back(v(0, 1, 16'h0008, 16'h2222, 0, 16'h0, 1, 0, 4'b0001));
    tbl.push_back(v(0, 1, 16'h0008, 16'h2222, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(v(1, 0, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(idle(1, 16'h1111, 4'b0001));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(v(1, 0, 16'h0008, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(idle(1, 16'h2222, 4'b0001));
    tbl.push_back(idle(0, 16'h0, 4'b0001));
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    // Errors: no access, busy untouched, memory untouched, err wins over stall
    tbl.push_back(v(0, 1, 16'h0002, 16'h1234, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(v(1, 1, 16'h0002, 16'h5555, 0, 16'h0, 0, 1, 4'b0010));
    tbl.push_back(idle(0, 16'h0, 4'b0010));
    tbl.push_back(idle(0, 16'h0, 4'b0010));
    tbl.push_back(v(1, 1, 16'h0002, 16'h5555, 0, 16'h0, 0, 1, 4'b0000));
    tbl.push_back(v(1, 0, 16'h0003, 16'h0, 0, 16'h0, 0, 1, 4'b0000));
    tbl.push_back(v(0, 1, 16'h0003, 16'h5555, 0, 16'h0, 0, 1, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b0000));
    tbl.push_back(v(1, 0, 16'h0002, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b0010));
    tbl.push_back(idle(1, 16'h1234, 4'b0010));
    tbl.push_back(idle(0, 16'h0, 4'b0010));
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    // Writeback B0..B3 to 0x0040 block, then fill from 0x1230 block
    tbl.push_back(v(0, 1, 16'h0040, 16'h00B0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(v(0, 1, 16'h0042, 16'h00B1, 0, 16'h0, 0, 0, 4'b0001));
    tbl.push_back(v(0, 1, 16'h0044, 16'h00B2, 0, 16'h0, 0, 0, 4'b0011));
    tbl.push_back(v(0, 1, 16'h0046, 16'h00B3, 0, 16'h0, 0, 0, 4'b0111));
    tbl.push_back(v(1, 0, 16'h1230, 16'h0, 0, 16'h0, 0, 0, 4'b1110));
    tbl.push_back(v(1, 0, 16'h1232, 16'h0, 0, 16'h0, 0, 0, 4'b1101));
    tbl.push_back(v(1, 0, 16'h1234, 16'h0, 1, 16'h00A0, 0, 0, 4'b1011));
    tbl.push_back(v(1, 0, 16'h1236, 16'h0, 1, 16'h00A1, 0, 0, 4'b0111));
    tbl.push_back(idle(1, 16'h00A2, 4'b1110));
    tbl.push_back(idle(1, 16'h00A3, 4'b1100));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(v(1, 0, 16'h0046, 16'h0, 0, 16'h0, 0, 0, 4'b0000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(1, 16'h00B3, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b1000));
    tbl.push_back(idle(0, 16'h0, 4'b0000));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      @(negedge clk);
      chk($sformatf("row%0d {valid,data,stall,err,busy}", i),
          32'({bif.data_valid, bif.data_out, bif.stall, bif.err, bif.busy}),
          32'({tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ee, tbl[i].eb}));
      next_cycle();
    end

    // Reset while a read is in flight: pipeline and counters clear, memory survives
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    @(negedge clk);
    chk("rst_seq accept stall", 32'(bif.stall), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_seq busy before reset", 32'(bif.busy), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("rst_seq busy on reset", 32'(bif.busy), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst_seq data_valid", 32'(bif.data_valid), 32'd0);
    chk("rst_seq data_out", 32'(bif.data_out), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst_seq stage1 not yet out", 32'(bif.data_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_seq readback", 32'({bif.data_valid, bif.data_out}), 32'({1'b1, 16'hBEEF}));
    next_cycle();
    @(negedge clk);
    chk("rst_seq single-cycle valid", 32'(bif.data_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
